// File: rtl/store_pkg.sv
// Shared encodings for the store-narrowing datapath: size codes, FSM states
// and the alignment rule applied when a store is accepted.
package store_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        MERGE,
        WRITE,
        DONE,
        ERR
    } state_e;

    // Byte stores can never be misaligned; the reserved size always faults.
    function automatic logic store_err(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_WORD: bad = (offset != 2'b00);
            SZ_HALF: bad = offset[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational little-endian lane merge: overlays the low bits of new_i onto
// old_i at the lanes selected by size_i and offset_i.
module byte_lane_merge
    import store_pkg::*;
(
    input  logic [31:0] old_i,
    input  logic [31:0] new_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] merged_o
);

    always_comb begin
        merged_o = old_i;
        case (size_i)
            SZ_WORD: merged_o = new_i;
            SZ_HALF: begin
                if (offset_i[1]) begin
                    merged_o[31:16] = new_i[15:0];
                end else begin
                    merged_o[15:0] = new_i[15:0];
                end
            end
            SZ_BYTE: merged_o[8*offset_i +: 8] = new_i[7:0];
            default: merged_o = old_i;
        endcase
    end

endmodule

// File: rtl/store_size_unit.sv
// Multicycle store unit: word stores write directly, sub-word stores perform a
// read-modify-write of the containing word.
module store_size_unit
    import store_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] old_q, old_d;
    logic [31:0] merged_q, merged_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] merge_out;
    logic [31:0] wr_data;

    byte_lane_merge u_merge (
        .old_i    (old_q),
        .new_i    (wdata_q),
        .size_i   (size_q),
        .offset_i (addr_q[1:0]),
        .merged_o (merge_out)
    );

    assign wr_data = (size_q == SZ_WORD) ? wdata_q : merged_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        old_d       = old_q;
        merged_d    = merged_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    size_d  = size;
                    if (store_err(size, addr[1:0])) begin
                        state_d = ERR;
                    end else if (size == SZ_WORD) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:  state_d = WAIT;
            WAIT: begin
                old_d   = mem_rdata;
                state_d = MERGE;
            end
            MERGE: begin
                merged_d = merge_out;
                state_d  = WRITE;
            end
            WRITE: begin
                mem_wdata_d = wr_data;
                state_d     = DONE;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            old_q       <= '0;
            merged_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            old_q       <= old_d;
            merged_q    <= merged_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Strobes decode straight from state so an async reset kills them at once.
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wr    = (state_q == WRITE);
    assign mem_wdata = (state_q == WRITE) ? wr_data : mem_wdata_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE) || (state_q == ERR);
    assign err       = (state_q == ERR);

endmodule

// File: tb/tb_store_size_unit.sv
// Directed bench for store_size_unit with a word memory model and a queue of
// expected memory writes checked whenever the DUT writes.
module tb_store_size_unit;
    import store_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] mem [0:63];
    int          compared = 0;
    int          mismatched = 0;
    int          write_cnt = 0;
    int          done_cnt = 0;

    store_size_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: read data valid the cycle after the address.
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[7:2]];
        if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write scoreboard: every DUT write must match the oldest expected write.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mem_wr) begin
            write_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", mem_addr, e.a);
                chk("write_data", mem_wdata, e.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Start a store at the current negedge (cycle 0) and check the cycle-by-cycle
    // handshake. With poke set, start is re-pulsed during cycle 1.
    task automatic run_store(input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input bit is_err, input bit poke);
        int          lat;
        logic [31:0] tmp;
        wr_t         e;
        lat = is_err ? 1 : ((sz == SZ_WORD) ? 2 : 5);
        if (!is_err) begin
            tmp = mem[a[7:2]];
            case (sz)
                SZ_WORD: tmp = wd;
                SZ_HALF: if (a[1]) tmp[31:16] = wd[15:0]; else tmp[15:0] = wd[15:0];
                default: tmp[8*a[1:0] +: 8] = wd[7:0];
            endcase
            e.a = {a[31:2], 2'b00};
            e.d = tmp;
            exp_q.push_back(e);
        end
        start = 1'b1;
        size  = sz;
        addr  = a;
        wdata = wd;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            chk($sformatf("busy_c%0d", k), {31'd0, busy}, 32'd1);
            chk($sformatf("mem_wr_c%0d", k), {31'd0, mem_wr},
                {31'd0, (!is_err && k == lat - 1)});
            chk($sformatf("done_c%0d", k), {31'd0, done}, {31'd0, (k == lat)});
            chk($sformatf("err_c%0d", k), {31'd0, err}, {31'd0, (is_err && k == lat)});
            if (poke && k == 1) begin
                start = 1'b1;
                size  = SZ_WORD;
                addr  = 32'h0000_0040;
                wdata = 32'h0BAD_0BAD;
            end
            @(negedge clk);
            start = 1'b0;
        end
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("done_idle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int wc;
        int dc;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        reset = 1'b1;
        start = 1'b0;
        size  = SZ_WORD;
        addr  = 32'h0;
        wdata = 32'h0;
        #1;
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_store(SZ_WORD, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("word_mem", mem[4], 32'hDEAD_BEEF);
        chk("word_held_wdata", mem_wdata, 32'hDEAD_BEEF);

        mem[4] = 32'h1122_3344;
        run_store(SZ_BYTE, 32'h0000_0013, 32'h0000_00AB, 1'b0, 1'b0);
        chk("byte_mem", mem[4], 32'hAB22_3344);

        mem[8] = 32'h1122_3344;
        run_store(SZ_HALF, 32'h0000_0022, 32'hFFFF_CAFE, 1'b0, 1'b0);
        chk("half_mem", mem[8], 32'hCAFE_3344);

        wc = write_cnt;
        run_store(SZ_HALF, 32'h0000_0005, 32'h1234_5678, 1'b1, 1'b0);
        run_store(SZ_WORD, 32'h0000_0002, 32'h1234_5678, 1'b1, 1'b0);
        run_store(SZ_RSVD, 32'h0000_0000, 32'h1234_5678, 1'b1, 1'b0);
        chk("err_no_write", write_cnt, wc);

        // Start during READ is dropped; restart in the first IDLE cycle works.
        mem[12] = 32'h5566_7788;
        mem[16] = 32'h0;
        wc = write_cnt;
        dc = done_cnt;
        run_store(SZ_BYTE, 32'h0000_0031, 32'h0000_0099, 1'b0, 1'b1);
        chk("poke_writes", write_cnt, wc + 1);
        chk("poke_dones", done_cnt, dc + 1);
        chk("poke_byte_mem", mem[12], 32'h5566_9988);
        chk("poke_ignored_mem", mem[16], 32'h0);
        run_store(SZ_WORD, 32'h0000_0044, 32'h1234_5678, 1'b0, 1'b0);
        chk("b2b_mem", mem[17], 32'h1234_5678);

        // Reset during MERGE aborts the halfword store.
        wc = write_cnt;
        start = 1'b1;
        size  = SZ_HALF;
        addr  = 32'h0000_0020;
        wdata = 32'h0000_BEEF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("mrst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_err", {31'd0, err}, 32'd0);
        chk("mrst_mem_addr", mem_addr, 32'd0);
        chk("mrst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mrst_no_write", write_cnt, wc);
        chk("mrst_mem_kept", mem[8], 32'hCAFE_3344);
        run_store(SZ_WORD, 32'h0000_0050, 32'hA5A5_5A5A, 1'b0, 1'b0);
        chk("post_rst_mem", mem[20], 32'hA5A5_5A5A);

        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
